vga_timing_gen: RTL and testbench

//  Raster timing source for the 640x480@60 game-console display path.

---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing source and its consumers.
// pix_en only exists when VGA_TIMING_CLKEN_EN is defined.
interface vga_timing_gen_if;
`ifdef VGA_TIMING_CLKEN_EN
  logic        pix_en;
`endif
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        hsync;
  logic        vsync;
  logic        display_on;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;

  // Timing source side
  modport master (
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
`ifdef VGA_TIMING_CLKEN_EN
    , input pix_en
`endif
  );

  // Render / game-logic side
  modport slave (
    input hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
`ifdef VGA_TIMING_CLKEN_EN
    , output pix_en
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source for a 640x480@60 display path: free-running H/V counters,
// syncs, display enable, line/frame strobes and a frame counter, all registered.
// Optional macro VGA_TIMING_CLKEN_EN adds a pixel clock enable (pix_en); when it is
// undefined the counters advance on every clk edge.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input logic              clk,
  input logic              reset_n,
  vga_timing_gen_if.master timing_io
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HDisp      = 10'(H_DISPLAY);
  localparam logic [9:0] VDisp      = 10'(V_DISPLAY);
  localparam logic [9:0] HSyncStart = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0]  hpos_q, hpos_d;
  logic [9:0]  vpos_q, vpos_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        display_on_q, display_on_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        adv;

`ifdef VGA_TIMING_CLKEN_EN
  assign adv = timing_io.pix_en;
`else
  assign adv = 1'b1;
`endif

  // Next counter position; syncs/enables/strobes decoded from it so they align with hpos/vpos
  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_cnt_d   = frame_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    display_on_d  = display_on_q;
    // Strobes drop on non-advancing edges so they last a single clk
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (adv) begin
      if (hpos_q >= HLast) begin
        hpos_d = '0;
        if (vpos_q >= VLast) begin
          vpos_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
        // Recover from an impossible out-of-range line without waiting for a wrap
        if (vpos_q > VLast) vpos_d = '0;
      end
      hsync_d       = ~(((hpos_d >= HSyncStart) && (hpos_d < HSyncEnd)) ^ SYNC_POL);
      vsync_d       = ~(((vpos_d >= VSyncStart) && (vpos_d < VSyncEnd)) ^ SYNC_POL);
      display_on_d  = (hpos_d < HDisp) && (vpos_d < VDisp);
      line_start_d  = (hpos_d == '0);
      frame_start_d = (hpos_d == '0) && (vpos_d == '0);
    end
  end

  // State and output registers; reset parks on the last pixel so the first advance hits (0,0)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hpos_q        <= HLast;
      vpos_q        <= VLast;
      frame_cnt_q   <= 16'hFFFF;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign timing_io.hpos        = hpos_q;
  assign timing_io.vpos        = vpos_q;
  assign timing_io.frame_cnt   = frame_cnt_q;
  assign timing_io.hsync       = hsync_q;
  assign timing_io.vsync       = vsync_q;
  assign timing_io.display_on  = display_on_q;
  assign timing_io.line_start  = line_start_q;
  assign timing_io.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (active-low syncs) and a
// tiny-raster instance with active-high syncs so whole frames fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        hs;
    logic        vs;
    logic        don;
    logic        ls;
    logic        fs;
    logic [15:0] fcnt;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();

  vga_timing_gen u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .timing_io (a_if.master)
  );

  vga_timing_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .SYNC_POL  (1'b1)
  ) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .timing_io (b_if.master)
  );

  obs_t a_obs, b_obs;
  assign a_obs = {a_if.hpos, a_if.vpos, a_if.hsync, a_if.vsync, a_if.display_on,
                  a_if.line_start, a_if.frame_start, a_if.frame_cnt};
  assign b_obs = {b_if.hpos, b_if.vpos, b_if.hsync, b_if.vsync, b_if.display_on,
                  b_if.line_start, b_if.frame_start, b_if.frame_cnt};

  obs_t qa[$];
  obs_t qb[$];
  obs_t ma, mb;

  function automatic obs_t model_reset(int unsigned ht, int unsigned vt, bit pol);
    obs_t r;
    r.hpos = 10'(ht - 1);
    r.vpos = 10'(vt - 1);
    r.hs   = !pol;
    r.vs   = !pol;
    r.don  = 1'b0;
    r.ls   = 1'b0;
    r.fs   = 1'b0;
    r.fcnt = 16'hFFFF;
    return r;
  endfunction

  function automatic obs_t model_step(obs_t c, int unsigned hd, int unsigned hf,
                                      int unsigned hs, int unsigned hb, int unsigned vd,
                                      int unsigned vf, int unsigned vs, int unsigned vb,
                                      bit pol);
    obs_t n;
    int unsigned ht, vt, h, v;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    h = int'(c.hpos);
    v = int'(c.vpos);
    n.fcnt = c.fcnt;
    if (h == ht - 1) begin
      h = 0;
      if (v == vt - 1) begin
        v = 0;
        n.fcnt = c.fcnt + 16'd1;
      end else begin
        v = v + 1;
      end
    end else begin
      h = h + 1;
    end
    n.hpos = 10'(h);
    n.vpos = 10'(v);
    n.hs   = ((h >= hd + hf) && (h < hd + hf + hs)) ? pol : !pol;
    n.vs   = ((v >= vd + vf) && (v < vd + vf + vs)) ? pol : !pol;
    n.don  = (h < hd) && (v < vd);
    n.ls   = (h == 0);
    n.fs   = (h == 0) && (v == 0);
    return n;
  endfunction

  task automatic check_queues(input string tag);
    obs_t e;
    while (qa.size() > 0) begin
      e = qa.pop_front();
      total++;
      assert (a_obs === e) else begin
        bad++;
        $error("FAIL %s dutA observed=%h expected=%h", tag, a_obs, e);
      end
    end
    while (qb.size() > 0) begin
      e = qb.pop_front();
      total++;
      assert (b_obs === e) else begin
        bad++;
        $error("FAIL %s dutB observed=%h expected=%h", tag, b_obs, e);
      end
    end
  endtask

  task automatic push_reset();
    ma = model_reset(800, 525, 1'b0);
    mb = model_reset(15, 8, 1'b1);
    qa.push_back(ma);
    qb.push_back(mb);
  endtask

  // One advance of both DUTs: predict, push, clock, then compare away from the edge
  task automatic tick(input string tag);
    ma = model_step(ma, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    mb = model_step(mb, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1);
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge clk);
    #1;
    check_queues(tag);
  endtask

  initial begin
    int hs_cnt, don_cnt, ls_first, ls_second, vs_cnt, fs_first, fs_second;
    hs_cnt = 0; don_cnt = 0; ls_first = -1; ls_second = -1;
    vs_cnt = 0; fs_first = -1; fs_second = -1;
`ifdef VGA_TIMING_CLKEN_EN
    a_if.pix_en = 1'b1;
    b_if.pix_en = 1'b1;
`endif
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_reset();
    check_queues("reset");
    reset_n = 1'b1;

    // Two full lines of the default raster; tiny raster runs ~13 frames meanwhile
    for (int i = 1; i <= 1600; i++) begin
      tick("run");
      if (i <= 800) begin
        if (a_if.hsync == 1'b0) hs_cnt++;
        if (a_if.display_on) don_cnt++;
      end
      if (a_if.line_start) begin
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
      if (i <= 120 && b_if.vsync == 1'b1) vs_cnt++;
      if (b_if.frame_start) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end

    total++;
    assert (hs_cnt == 96) else begin
      bad++; $error("FAIL hsync_width observed=%0d expected=96", hs_cnt);
    end
    total++;
    assert (don_cnt == 640) else begin
      bad++; $error("FAIL display_width observed=%0d expected=640", don_cnt);
    end
    total++;
    assert (ls_first == 1 && ls_second - ls_first == 800) else begin
      bad++; $error("FAIL line_period observed=%0d,%0d expected=1,801", ls_first, ls_second);
    end
    total++;
    assert (vs_cnt == 30) else begin
      bad++; $error("FAIL vsync_width observed=%0d expected=30", vs_cnt);
    end
    total++;
    assert (fs_first == 1 && fs_second - fs_first == 120) else begin
      bad++; $error("FAIL frame_period observed=%0d,%0d expected=1,121", fs_first, fs_second);
    end

    // Walk to hpos=300 on line 2, then hit reset between clock edges
    for (int i = 0; i < 301; i++) tick("to_mid");
    #2;
    reset_n = 1'b0;
    #1;
    push_reset();
    check_queues("async_reset");
    @(posedge clk);
    #1;
    push_reset();
    check_queues("reset_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
